// File: rtl/frame_buffer_writer.sv
// Raster-order pixel stream writer for the dual-port VGA frame buffer.
// Optional pre-load clear of the whole buffer is built when FRAME_CLEAR_EN is defined.
module frame_buffer_writer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              frame_done,
    output logic              sync_err
);

    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

`ifdef FRAME_CLEAR_EN
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    typedef enum logic [1:0] {IDLE, CLEAR, WRITE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

    state_t            state;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;

    logic              xfer;
    logic              resync;
    logic              last;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [ADDR_W-1:0] cur_addr;

    assign pix_ready = (state == WRITE);
    assign busy      = (state != IDLE);

    // A mid-frame sof re-bases the current pixel to (0,0) before the usual advance.
    always_comb begin
        xfer     = pix_valid & pix_ready;
        resync   = pix_sof && ((x != '0) || (y != '0));
        cur_x    = resync ? '0 : x;
        cur_y    = resync ? '0 : y;
        cur_addr = resync ? '0 : addr;
        last     = (cur_x == X_LAST) && (cur_y == Y_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x    <= '0;
                        y    <= '0;
                        addr <= '0;
`ifdef FRAME_CLEAR_EN
                        // First clear write is issued here so CLEAR shows exactly one write per cycle.
                        state    <= CLEAR;
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        mem_data <= '0;
`else
                        state <= WRITE;
`endif
                    end
                end
`ifdef FRAME_CLEAR_EN
                CLEAR: begin
                    if (mem_addr == A_LAST) begin
                        state <= WRITE;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_data <= '0;
                    end
                end
`endif
                WRITE: begin
                    if (xfer) begin
                        mem_we   <= 1'b1;
                        mem_addr <= cur_addr;
                        mem_data <= pix_data;
                        sync_err <= resync;
                        if (last) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            x          <= '0;
                            y          <= '0;
                            addr       <= '0;
                        end else begin
                            addr <= cur_addr + ADDR_W'(1);
                            if (cur_x == X_LAST) begin
                                x <= '0;
                                y <= cur_y + Y_W'(1);
                            end else begin
                                x <= cur_x + X_W'(1);
                                y <= cur_y;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
Write-side companion of the VGA display path. Accepts an 8-bit grayscale pixel stream over a valid/ready handshake and writes it raster-order into the dual-port frame buffer. The VGA controller reads the same buffer through its 16-bit address / 8-bit data port. Raster order: address = y*IMG_W + x. Provides start/busy/frame_done control for the top-level loader (UART/ROM/filter front end).

Parameters:
IMG_W, 256, pixels per line.
IMG_H, 256, lines per frame.
ADDR_W, 16, frame buffer address width; IMG_W*IMG_H <= 2^ADDR_W is required.
DATA_W, 8, pixel width.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins a frame load; ignored while busy=1.
pix_data  in  DATA_W  stream pixel.
pix_valid  in  1  pix_data is valid.
pix_sof  in  1  start-of-frame marker, qualified by pix_valid.
pix_ready  out  1  writer can accept a pixel.
mem_we  out  1  frame buffer write enable.
mem_addr  out  ADDR_W  frame buffer write address.
mem_data  out  DATA_W  frame buffer write data.
busy  out  1  high from the cycle after an accepted start until frame_done.
frame_done  out  1  one-cycle pulse when the last pixel has been written.
sync_err  out  1  one-cycle pulse on an unexpected pix_sof.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; x, y and address counters clear to 0.
  - All outputs are 0. No mem_we is issued after reset asserts.
- FSM states: IDLE, CLEAR (only with the optional feature), WRITE, DONE.
- IDLE:
  - pix_ready=0, busy=0.
  - start=1 -> WRITE (or CLEAR when the feature is enabled).
- WRITE:
  - pix_ready=1, decoded combinationally from the state register only.
  - A transfer is a cycle with pix_valid & pix_ready.
- Write timing (latency 1):
  - The cycle after a transfer: mem_we=1, mem_addr = address of the transferred pixel, mem_data = its pix_data.
  - mem_we is 0 in every other cycle.
- Counters:
  - x counts 0..IMG_W-1. On a transfer at x=IMG_W-1, x wraps to 0 and y increments.
  - Address is a running counter incremented by 1 per transfer; no multiplier is used.
- Frame end:
  - A transfer at (x=IMG_W-1, y=IMG_H-1) moves the FSM to DONE, so pix_ready=0 in the following cycle.
  - No extra pixel is ever accepted.
- DONE (one cycle):
  - frame_done=1 in the same cycle as the last mem_we.
  - Next state is IDLE; busy drops in that IDLE cycle.
- pix_sof with a transfer at position (0,0): normal transfer, no error.
- pix_sof with a transfer at any other position:
  - Counters resynchronise; this pixel is written to address 0.
  - Next pixel goes to address 1.
  - sync_err pulses in the same cycle as that write.
- A first pixel without pix_sof is accepted and written to address 0.
- pix_valid while pix_ready=0: ignored; the upstream source must hold its data.
- start pulses while busy=1 have no effect.

Optional Feature:
FRAME_CLEAR_EN
- Defined:
  - After start, the FSM enters CLEAR and writes 0 to addresses 0..IMG_W*IMG_H-1, one per cycle (mem_we=1), with pix_ready=0 and busy=1.
  - After the last clear write it enters WRITE.
  - A frame load therefore takes IMG_W*IMG_H extra cycles.
- Undefined: the CLEAR state and its logic are absent; start goes directly to WRITE.

Test Plan:
- IMG_W=4, IMG_H=2; start, then 8 back-to-back pixels 0x10..0x17 with sof on the first -> mem_we on 8 consecutive cycles, addresses 0..7, data 0x10..0x17; frame_done coincides with the addr-7 write; pix_ready=0 thereafter.
- Same config, pix_valid toggled 1/0 every cycle -> 8 writes at addresses 0..7, none duplicated or skipped; busy stays high until frame_done.
- pix_sof asserted on the 3rd pixel (0xAA) -> sync_err pulse; 0xAA written at address 0; following pixels at 1..7; frame_done after 8 post-sync pixels.
- rst_n pulled low after 5 transfers -> mem_we, busy and pix_ready go 0 immediately; after release the writer stays in IDLE until start; a new frame begins at address 0.
- start pulsed again mid-frame, and pix_valid driven in IDLE -> no state change, no writes, pix_ready remains 0 in IDLE.
- FRAME_CLEAR_EN defined, IMG_W=4, IMG_H=2 -> 8 writes of 0x00 at addresses 0..7 with pix_ready=0, then normal pixel writes at 0..7.
